// File: rtl/cp0_ext.sv
// MIPS-style coprocessor 0 subset: Count/Compare timer, SR, Cause, EPC, BadVAddr, PRId,
// exception entry/return bookkeeping and interrupt request generation.
module cp0_ext #(
  parameter int unsigned NUM_HWINT  = 5,
  parameter int unsigned COUNT_DIV  = 1,
  parameter logic [31:0] PRID_VALUE = 32'h0000_0000
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [4:0]           a_rd,
  input  logic [4:0]           a_wr,
  input  logic [31:0]          wd,
  input  logic                 we,
  output logic [31:0]          rd,
  input  logic [31:0]          pc,
  input  logic                 bd_in,
  input  logic                 exc_req,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          bad_vaddr_in,
  input  logic                 eret,
  input  logic [NUM_HWINT-1:0] hw_int,
  output logic [31:0]          epc,
  output logic                 int_req,
  output logic                 timer_int
);

  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegCount    = 5'd9;
  localparam logic [4:0] RegCompare  = 5'd11;
  localparam logic [4:0] RegSr       = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;
  localparam logic [4:0] RegPrid     = 5'd15;
  localparam logic [7:0] PrescMax    = 8'(COUNT_DIV - 1);

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic [1:0]  sw_ip_q, sw_ip_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [7:0]  presc_q, presc_d;

  logic [7:0]  ip_live;
  logic        wr_sr, wr_cause, wr_epc, wr_count, wr_compare;
  logic        count_tick;
  logic [31:0] epc_exc;

  assign wr_sr      = we && (a_wr == RegSr);
  assign wr_cause   = we && (a_wr == RegCause);
  assign wr_epc     = we && (a_wr == RegEpc);
  assign wr_count   = we && (a_wr == RegCount);
  assign wr_compare = we && (a_wr == RegCompare);
  assign count_tick = (presc_q == PrescMax);
  assign epc_exc    = (bd_in ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;

  always_comb begin
    ip_live      = '0;
    ip_live[1:0] = sw_ip_q;
    for (int k = 0; k < NUM_HWINT; k++) begin
      ip_live[2+k] = hw_int[k];
    end
    ip_live[7]   = ti_q;
  end

  assign int_req   = ie_q & ~exl_q & (|(im_q & ip_live));
  assign epc       = epc_q;
  assign timer_int = ti_q;

  always_comb begin
    rd = '0;
    case (a_rd)
      RegBadVAddr: rd = badvaddr_q;
      RegCount:    rd = count_q;
      RegCompare:  rd = compare_q;
      RegSr:       rd = {16'b0, im_q, 6'b0, exl_q, ie_q};
      RegCause:    rd = {bd_q, ti_q, 14'b0, ip_hw_q, sw_ip_q, 1'b0, exc_code_q, 2'b0};
      RegEpc:      rd = epc_q;
      RegPrid:     rd = PRID_VALUE;
      default:     rd = '0;
    endcase
  end

  always_comb begin
    im_d       = wr_sr ? wd[15:8] : im_q;
    ie_d       = wr_sr ? wd[0] : ie_q;
    sw_ip_d    = wr_cause ? wd[9:8] : sw_ip_q;
    ip_hw_d    = ip_live[7:2];
    compare_d  = wr_compare ? wd : compare_q;
    exc_code_d = exc_req ? exc_code : exc_code_q;
    badvaddr_d = (exc_req && (exc_code == 5'd4 || exc_code == 5'd5)) ? bad_vaddr_in
                                                                    : badvaddr_q;

    exl_d = exl_q;
    if (exc_req)    exl_d = 1'b1;
    else if (eret)  exl_d = 1'b0;
    else if (wr_sr) exl_d = wd[1];

    // A nested exception (EXL already set) keeps the original return point.
    epc_d = epc_q;
    bd_d  = bd_q;
    if (exc_req) begin
      if (!exl_q) begin
        epc_d = epc_exc;
        bd_d  = bd_in;
      end
    end else if (wr_epc) begin
      epc_d = {wd[31:2], 2'b00};
    end

    count_d = count_q;
    presc_d = presc_q + 8'd1;
    if (wr_count) begin
      count_d = wd;
      presc_d = '0;
    end else if (count_tick) begin
      count_d = count_q + 32'd1;
      presc_d = '0;
    end

    ti_d = ti_q;
    if (wr_compare)                                           ti_d = 1'b0;
    else if ((wr_count || count_tick) && count_d == compare_q) ti_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      sw_ip_q    <= '0;
      ip_hw_q    <= '0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      exc_code_q <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      presc_q    <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      sw_ip_q    <= sw_ip_d;
      ip_hw_q    <= ip_hw_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      presc_q    <= presc_d;
    end
  end

endmodule

// File: tb/tb_cp0_ext.sv
// Scoreboard bench for cp0_ext: expected values are queued as stimulus is applied and
// compared against the read port / status outputs once the DUT has settled.
module tb_cp0_ext;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  a_rd, a_wr, exc_code;
  logic [31:0] wd, pc, bad_vaddr_in;
  logic        we, bd_in, exc_req, eret;
  logic [4:0]  hw_int;
  logic [31:0] rd, epc;
  logic        int_req, timer_int;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  typedef struct {
    string       tag;
    int unsigned kind;  // 0 read port, 1 epc, 2 int_req, 3 timer_int
    logic [4:0]  addr;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];

  cp0_ext dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .a_rd         (a_rd),
    .a_wr         (a_wr),
    .wd           (wd),
    .we           (we),
    .rd           (rd),
    .pc           (pc),
    .bd_in        (bd_in),
    .exc_req      (exc_req),
    .exc_code     (exc_code),
    .bad_vaddr_in (bad_vaddr_in),
    .eret         (eret),
    .hw_int       (hw_int),
    .epc          (epc),
    .int_req      (int_req),
    .timer_int    (timer_int)
  );

  always #50 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int unsigned kind, input logic [4:0] addr,
                      input logic [31:0] v);
    sb_t e;
    e.tag  = tag;
    e.kind = kind;
    e.addr = addr;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic exp_reg(input string tag, input logic [4:0] addr, input logic [31:0] v);
    push(tag, 0, addr, v);
  endtask

  task automatic drain();
    sb_t e;
    logic [31:0] got;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      got = '0;
      if (e.kind == 0) a_rd = e.addr;
      #1;
      case (e.kind)
        0:       got = rd;
        1:       got = epc;
        2:       got = {31'b0, int_req};
        default: got = {31'b0, timer_int};
      endcase
      check_eq(e.tag, got, e.exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    we   = 1'b1;
    a_wr = addr;
    wd   = data;
    step();
    we   = 1'b0;
  endtask

  task automatic raise_exc(input logic [4:0] code, input logic [31:0] p, input logic bd,
                           input logic [31:0] bad);
    exc_req      = 1'b1;
    exc_code     = code;
    pc           = p;
    bd_in        = bd;
    bad_vaddr_in = bad;
  endtask

  initial begin
    Rst = 1'b1; a_rd = '0; a_wr = '0; wd = '0; we = 1'b0; pc = '0; bd_in = 1'b0;
    exc_req = 1'b0; exc_code = '0; bad_vaddr_in = '0; eret = 1'b0; hw_int = '0;

    // Reset wins over simultaneous exception, eret, write and interrupts.
    raise_exc(5'd4, 32'h1234, 1'b1, 32'hBEEF);
    eret = 1'b1; we = 1'b1; a_wr = 5'd12; wd = 32'hFFFF_FFFF; hw_int = 5'h1F;
    step();
    step();
    exp_reg("rst_sr", 12, 0);        exp_reg("rst_cause", 13, 0);
    exp_reg("rst_epc", 14, 0);       exp_reg("rst_badva", 8, 0);
    exp_reg("rst_count", 9, 0);      exp_reg("rst_compare", 11, 0);
    exp_reg("rst_prid", 15, 0);
    push("rst_int_req", 2, 0, 0);    push("rst_ti", 3, 0, 0);
    push("rst_epc_port", 1, 0, 0);
    drain();
    Rst = 1'b0; exc_req = 1'b0; eret = 1'b0; we = 1'b0; hw_int = '0;

    mtc0(5'd3, 32'hFFFF_FFFF);
    exp_reg("unmapped3", 3, 0);
    exp_reg("unmapped10", 10, 0);
    drain();

    // Hardware interrupt: combinational request, Cause IP one cycle late.
    mtc0(5'd12, 32'h0000_0401);
    exp_reg("sr_401", 12, 32'h0000_0401);
    push("int_idle", 2, 0, 0);
    drain();
    hw_int = 5'b00001;
    push("int_hw0", 2, 0, 1);
    exp_reg("cause_ip_lag", 13, 0);
    drain();
    step();
    exp_reg("cause_ip2", 13, 32'h0000_0400);
    drain();
    hw_int = '0;
    push("int_hw0_off", 2, 0, 0);
    drain();
    step();

    // Only software IP bits of Cause are writable.
    mtc0(5'd13, 32'hFFFF_FFFF);
    exp_reg("cause_swip", 13, 32'h0000_0300);
    push("int_masked", 2, 0, 0);
    drain();
    mtc0(5'd12, 32'h0000_0101);
    push("int_sw0", 2, 0, 1);
    drain();
    mtc0(5'd13, 32'h0);
    push("int_sw0_off", 2, 0, 0);
    drain();
    mtc0(5'd12, 32'hFFFF_FFFF);
    exp_reg("sr_mask", 12, 32'h0000_FF03);
    push("int_exl_block", 2, 0, 0);
    drain();
    mtc0(5'd12, 32'h0);

    // Timer: Compare=10, Count=8.
    mtc0(5'd11, 32'd10);
    exp_reg("compare10", 11, 32'd10);
    drain();
    mtc0(5'd9, 32'd8);
    exp_reg("count8", 9, 32'd8);
    push("ti_c8", 3, 0, 0);
    drain();
    step();
    exp_reg("count9", 9, 32'd9);
    push("ti_c9", 3, 0, 0);
    drain();
    step();
    exp_reg("count10", 9, 32'd10);
    push("ti_c10", 3, 0, 1);
    exp_reg("cause_ti", 13, 32'h4000_0000);
    drain();
    step();
    exp_reg("cause_ti_ip7", 13, 32'h4000_8000);
    exp_reg("count11", 9, 32'd11);
    drain();
    mtc0(5'd11, 32'd11);  // equals Count at the write
    push("ti_clr", 3, 0, 0);
    exp_reg("compare11", 11, 32'd11);
    exp_reg("count12", 9, 32'd12);
    drain();
    step();
    push("ti_stays_clr", 3, 0, 0);
    drain();

    // Exception entry from EXL=0 in a delay slot, AdEL.
    raise_exc(5'd4, 32'h3004, 1'b1, 32'h1235);
    step();
    exc_req = 1'b0;
    exp_reg("exc1_epc", 14, 32'h3000);
    push("exc1_epc_port", 1, 0, 32'h3000);
    exp_reg("exc1_badva", 8, 32'h1235);
    exp_reg("exc1_sr", 12, 32'h2);
    exp_reg("exc1_cause", 13, 32'h8000_0010);
    drain();

    // Nested exception: EPC/BD hold, ExcCode updates, BadVAddr holds.
    raise_exc(5'd8, 32'h4000, 1'b0, 32'hDEAD);
    step();
    exc_req = 1'b0;
    exp_reg("exc2_epc", 14, 32'h3000);
    exp_reg("exc2_cause", 13, 32'h8000_0020);
    exp_reg("exc2_badva", 8, 32'h1235);
    drain();
    eret = 1'b1;
    step();
    eret = 1'b0;
    exp_reg("eret_sr", 12, 32'h0);
    drain();

    // Exception beats mtc0 EPC; exception beats eret.
    raise_exc(5'd0, 32'h6000, 1'b0, 32'h0);
    we = 1'b1; a_wr = 5'd14; wd = 32'h5000;
    step();
    exc_req = 1'b0; we = 1'b0;
    exp_reg("exc3_epc", 14, 32'h6000);
    exp_reg("exc3_cause", 13, 32'h0);
    drain();
    eret = 1'b1;
    step();
    raise_exc(5'd2, 32'h7000, 1'b0, 32'h0);
    step();
    exc_req = 1'b0; eret = 1'b0;
    exp_reg("exc_eret_sr", 12, 32'h2);
    exp_reg("exc_eret_epc", 14, 32'h7000);
    drain();
    eret = 1'b1;
    step();
    eret = 1'b0;

    // SR write still updates IM/IE alongside exc_req or eret.
    raise_exc(5'd1, 32'h8000, 1'b0, 32'h0);
    mtc0(5'd12, 32'h0000_FF01);
    exc_req = 1'b0;
    exp_reg("exc_sr_wr", 12, 32'h0000_FF03);
    drain();
    eret = 1'b1;
    mtc0(5'd12, 32'h0000_0403);
    eret = 1'b0;
    exp_reg("eret_sr_wr", 12, 32'h0000_0401);
    drain();
    mtc0(5'd12, 32'h0);
    mtc0(5'd14, 32'h1237);
    exp_reg("epc_wr_align", 14, 32'h1234);
    drain();

    // Count wrap onto Compare=0 sets TI.
    mtc0(5'd11, 32'h0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    exp_reg("count_max", 9, 32'hFFFF_FFFF);
    push("ti_before_wrap", 3, 0, 0);
    drain();
    step();
    exp_reg("count_wrap", 9, 32'h0);
    push("ti_wrap", 3, 0, 1);
    drain();
    mtc0(5'd12, 32'h0000_8001);
    push("int_timer", 2, 0, 1);
    drain();
    mtc0(5'd9, 32'hFFFF_FFFF);
    push("ti_held", 3, 0, 1);
    drain();

    // Reset with TI set and Count at max, plus competing inputs.
    Rst = 1'b1;
    raise_exc(5'd5, 32'h9000, 1'b1, 32'h4444);
    eret = 1'b1; we = 1'b1; a_wr = 5'd12; wd = 32'hFFFF_FFFF;
    step();
    exp_reg("rst2_count", 9, 0);     exp_reg("rst2_compare", 11, 0);
    exp_reg("rst2_sr", 12, 0);       exp_reg("rst2_cause", 13, 0);
    exp_reg("rst2_epc", 14, 0);      exp_reg("rst2_badva", 8, 0);
    push("rst2_int_req", 2, 0, 0);   push("rst2_ti", 3, 0, 0);
    drain();
    Rst = 1'b0; exc_req = 1'b0; eret = 1'b0; we = 1'b0;
    step();
    exp_reg("count_after_rst", 9, 32'd1);
    push("int_after_rst", 2, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cp0_ext.md
CP0_EXT -- requirements
Module: cp0_ext

Interface
REQ-001 Parameter NUM_HWINT, default 5, number of hardware interrupt lines; legal range 1..5.
REQ-002 Parameter COUNT_DIV, default 1, Count increments once every COUNT_DIV cycles; legal range 1..256.
REQ-003 Parameter PRID_VALUE, default 32'h0000_0000, constant value returned for PRId.
REQ-004 Clk  input  1  clock; all state updates on rising edge.
REQ-005 Rst  input  1  reset; synchronous, active-high.
REQ-006 a_rd  input  5  register number for the combinational read port.
REQ-007 a_wr  input  5  register number for the write (mtc0) port.
REQ-008 wd  input  32  write data.
REQ-009 we  input  1  write enable.
REQ-010 rd  output  32  read data.
REQ-011 pc  input  32  PC of the faulting instruction.
REQ-012 bd_in  input  1  faulting instruction is in a delay slot.
REQ-013 exc_req  input  1  exception/interrupt entry strobe, one cycle.
REQ-014 exc_code  input  5  ExcCode for the entry.
REQ-015 bad_vaddr_in  input  32  faulting address for AdEL/AdES.
REQ-016 eret  input  1  exception return strobe.
REQ-017 hw_int  input  NUM_HWINT  level hardware interrupt lines.
REQ-018 epc  output  32  current EPC value.
REQ-019 int_req  output  1  interrupt request to the pipeline.
REQ-020 timer_int  output  1  timer interrupt pending flag (TI).

Function
REQ-021 The register map SHALL be: 8 BadVAddr (RO), 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PRId (RO); all other numbers read 0 and ignore writes.
REQ-022 SR SHALL read {16'b0, IM[7:0], 6'b0, EXL, IE}; all of IM, EXL and IE are writable.
REQ-023 Cause SHALL read {BD, TI, 14'b0, IP[7:0], 1'b0, ExcCode, 2'b0}; only IP[1:0] (software interrupts) are writable.
REQ-024 The live pending vector SHALL be: IP[1:0] = software bits; IP[2+k] = hw_int[k] for k < NUM_HWINT; IP[7] = TI; all remaining bits 0.
REQ-025 The Cause read value of IP[7:2] SHALL be the live vector registered one cycle earlier.
REQ-026 int_req SHALL be combinational: IE & ~EXL & |(IM & live IP).
REQ-027 The read port SHALL be combinational; a same-cycle write SHALL NOT be visible until the next cycle.
REQ-028 Count SHALL increment by 1 (mod 2^32) each time a prescaler counting 0..COUNT_DIV-1 wraps.
REQ-029 An mtc0 to Count SHALL load wd, reset the prescaler, and override that cycle's increment.
REQ-030 TI SHALL set on the cycle Count transitions to a value equal to Compare, and SHALL stay set until Compare is written.
REQ-031 An mtc0 to Compare SHALL clear TI, even if wd equals the current Count.
REQ-032 A write to EPC SHALL store {wd[31:2], 2'b00}.
REQ-033 exc_req SHALL set EXL and load ExcCode on the next edge.
REQ-034 On exc_req with EXL=0, EPC SHALL load (bd_in ? pc-4 : pc) with bits [1:0] forced to 0, and BD SHALL load bd_in.
REQ-035 On exc_req with EXL=1, EPC and BD SHALL hold their values.
REQ-036 On exc_req with exc_code 4 (AdEL) or 5 (AdES), BadVAddr SHALL load bad_vaddr_in; for any other code it SHALL hold.
REQ-037 eret SHALL clear EXL on the next edge.
REQ-038 Priority for EXL SHALL be exc_req > eret > mtc0 SR.
REQ-039 Priority for EPC SHALL be exc_req > mtc0 EPC.
REQ-040 mtc0 SR SHALL still update IM and IE in the same cycle as exc_req or eret.
REQ-041 epc SHALL always equal the EPC register.
REQ-042 timer_int SHALL always equal TI.

Reset
REQ-043 On Rst, SR, Cause (including IP, BD, TI, ExcCode), EPC, BadVAddr, Count, Compare and the prescaler SHALL all clear to 0.
REQ-044 Rst SHALL take priority over all other inputs, including simultaneous exc_req, eret and we.
REQ-045 During and after reset, int_req SHALL be 0 until SR is written.

Verification
REQ-046 Write SR=32'h0000_0401, raise hw_int[0] -> int_req=1 combinationally; Cause reads 32'h0000_0400 one cycle later.
REQ-047 COUNT_DIV=1, write Compare=10 then Count=8 -> TI=1 two cycles later; write Compare=20 -> TI=0 next cycle.
REQ-048 EXL=0, exc_req, exc_code=4, pc=32'h3004, bd_in=1, bad_vaddr_in=32'h1235 -> EPC=32'h3000, BD=1, BadVAddr=32'h1235, EXL=1, ExcCode=4.
REQ-049 EXL=1, exc_req with pc=32'h4000 -> EPC unchanged, ExcCode updated; then eret -> EXL=0.
REQ-050 Same cycle: exc_req and mtc0 EPC=32'h5000 -> EPC takes the pc-derived value; exc_req and eret together -> EXL=1.
REQ-051 Rst asserted while TI=1 and Count=32'hFFFF_FFFF -> all registers 0 next cycle, int_req=0; Count wrap 32'hFFFF_FFFF -> 0 with Compare=0 sets TI.
